// File: rtl/dma_pkg.sv
// Shared definitions for the DMA transfer sequencer: state encoding,
// channel control bit positions and transfer direction constants.
package dma_pkg;

    // One single-mode transfer walks SI -> S0 -> S1 -> S2 -> S3 -> S4 -> SI
    typedef enum logic [2:0] {
        ST_SI = 3'd0,
        ST_S0 = 3'd1,
        ST_S1 = 3'd2,
        ST_S2 = 3'd3,
        ST_S3 = 3'd4,
        ST_S4 = 3'd5
    } dma_state_e;

    // Bit positions inside cfg_ctrl
    localparam int CTRL_DIR      = 0;
    localparam int CTRL_AUTOINIT = 1;
    localparam int CTRL_ADDR_DEC = 2;
    localparam int CTRL_MASK     = 3;

    // Transfer direction: read strobes MEMR, write strobes MEMW
    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

endpackage

// File: rtl/dma_priority_arbiter.sv
// Combinational channel arbiter. Fixed mode: lowest index wins.
// Rotating mode: search starts just after the last-serviced channel.
module dma_priority_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         eligible,
    input  logic                      rotate_pri,
    input  logic [$clog2(NUM_CH)-1:0] last_ch,
    output logic [NUM_CH-1:0]         grant,
    output logic [$clog2(NUM_CH)-1:0] grant_idx,
    output logic                      any_grant
);
    localparam int IDX_W = $clog2(NUM_CH);

    logic [IDX_W-1:0] start_s;
    logic [IDX_W-1:0] cand_s;

    // Walk candidates from lowest to highest priority so the best one is written last
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand_s    = '0;
        if (rotate_pri) begin
            start_s = last_ch + IDX_W'(1);
        end else begin
            start_s = '0;
        end
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand_s = IDX_W'((int'(start_s) + k) % NUM_CH);
            if (eligible[cand_s]) begin
                grant     = NUM_CH'(1) << cand_s;
                grant_idx = cand_s;
                any_grant = 1'b1;
            end else begin
                any_grant = any_grant;
            end
        end
    end

endmodule

// File: rtl/dma_transfer_sequencer.sv
// Per-transfer sequencer for the 4-channel DMA controller: arbitration,
// HRQ/HLDA handshake, S-state strobe sequencing, per-channel address/count
// registers and terminal-count reporting. All outputs are registered.
module dma_transfer_sequencer
    import dma_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] dreq,
    input  logic              hlda,
    input  logic              rotate_pri,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_ch,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic [3:0]        cfg_ctrl,
    input  logic              status_rd,
    output logic              hrq,
    output logic [NUM_CH-1:0] dack,
    output logic              aen,
    output logic              adstb,
    output logic              memr,
    output logic              memw,
    output logic              tc,
    output logic [ADDR_W-1:0] addr_out,
    output logic [NUM_CH-1:0] tc_flags,
    output logic [NUM_CH-1:0] mask_out
);
    localparam int IDX_W = $clog2(NUM_CH);

    dma_state_e        state_r;
    logic [IDX_W-1:0]  win_r;
    logic [NUM_CH-1:0] win_oh_r;
    logic [IDX_W-1:0]  pri_ptr_r;

    logic [ADDR_W-1:0] base_addr_r [NUM_CH];
    logic [ADDR_W-1:0] cur_addr_r  [NUM_CH];
    logic [CNT_W-1:0]  base_cnt_r  [NUM_CH];
    logic [CNT_W-1:0]  cur_cnt_r   [NUM_CH];
    logic [NUM_CH-1:0] dir_r;
    logic [NUM_CH-1:0] autoinit_r;
    logic [NUM_CH-1:0] dec_r;
    logic [NUM_CH-1:0] mask_r;
    logic [NUM_CH-1:0] tc_flags_r;

    logic [NUM_CH-1:0] eligible_s;
    logic [NUM_CH-1:0] arb_grant_s;
    logic [IDX_W-1:0]  arb_idx_s;
    logic              arb_any_s;
    logic [IDX_W-1:0]  last_ch_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [ADDR_W-1:0] step_addr_s;
    logic              tc_hit_s;
    logic              abort_s;
    logic              commit_s;

    assign eligible_s = dreq & ~mask_r;
    assign last_ch_s  = pri_ptr_r - IDX_W'(1);
    assign tc_flags   = tc_flags_r;
    assign mask_out   = mask_r;

    dma_priority_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .eligible   (eligible_s),
        .rotate_pri (rotate_pri),
        .last_ch    (last_ch_s),
        .grant      (arb_grant_s),
        .grant_idx  (arb_idx_s),
        .any_grant  (arb_any_s)
    );

    // Serviced channel's address step, TC detection and bus-loss / commit qualifiers
    always_comb begin
        win_addr_s = cur_addr_r[win_r];
        if (dec_r[win_r]) begin
            step_addr_s = win_addr_s - ADDR_W'(1);
        end else begin
            step_addr_s = win_addr_s + ADDR_W'(1);
        end
        tc_hit_s = (cur_cnt_r[win_r] == '0);
        abort_s  = ((state_r == ST_S1) || (state_r == ST_S2) || (state_r == ST_S3)) && !hlda;
        commit_s = (state_r == ST_S3) && hlda;
    end

    // Transfer FSM with registered bus-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_SI;
            win_r    <= '0;
            win_oh_r <= '0;
            hrq      <= 1'b0;
            dack     <= '0;
            aen      <= 1'b0;
            adstb    <= 1'b0;
            memr     <= 1'b0;
            memw     <= 1'b0;
            tc       <= 1'b0;
            addr_out <= '0;
        end else if (abort_s) begin
            state_r <= ST_SI;
            hrq     <= 1'b0;
            dack    <= '0;
            aen     <= 1'b0;
            adstb   <= 1'b0;
            memr    <= 1'b0;
            memw    <= 1'b0;
            tc      <= 1'b0;
        end else begin
            adstb <= 1'b0;
            tc    <= 1'b0;
            case (state_r)
                ST_SI: begin
                    dack <= '0;
                    aen  <= 1'b0;
                    memr <= 1'b0;
                    memw <= 1'b0;
                    if (arb_any_s) begin
                        win_r    <= arb_idx_s;
                        win_oh_r <= arb_grant_s;
                        hrq      <= 1'b1;
                        state_r  <= ST_S0;
                    end else begin
                        hrq     <= 1'b0;
                        state_r <= ST_SI;
                    end
                end
                ST_S0: begin
                    if (hlda) begin
                        state_r  <= ST_S1;
                        aen      <= 1'b1;
                        adstb    <= 1'b1;
                        dack     <= win_oh_r;
                        addr_out <= win_addr_s;
                    end else if ((dreq & win_oh_r) == '0) begin
                        state_r <= ST_SI;
                        hrq     <= 1'b0;
                    end else begin
                        state_r <= ST_S0;
                    end
                end
                ST_S1: begin
                    state_r <= ST_S2;
                    memr    <= (dir_r[win_r] == DIR_READ);
                end
                ST_S2: begin
                    state_r <= ST_S3;
                    memw    <= (dir_r[win_r] == DIR_WRITE);
                end
                ST_S3: begin
                    state_r  <= ST_S4;
                    memr     <= 1'b0;
                    memw     <= 1'b0;
                    tc       <= tc_hit_s;
                    addr_out <= step_addr_s;
                end
                ST_S4: begin
                    state_r <= ST_SI;
                    hrq     <= 1'b0;
                    dack    <= '0;
                    aen     <= 1'b0;
                end
                default: begin
                    state_r <= ST_SI;
                    hrq     <= 1'b0;
                    dack    <= '0;
                    aen     <= 1'b0;
                    memr    <= 1'b0;
                    memw    <= 1'b0;
                end
            endcase
        end
    end

    // Channel register file: programming, per-transfer update, TC flags, rotation pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                base_addr_r[ch] <= '0;
                cur_addr_r[ch]  <= '0;
                base_cnt_r[ch]  <= '0;
                cur_cnt_r[ch]   <= '0;
            end
            dir_r      <= '0;
            autoinit_r <= '0;
            dec_r      <= '0;
            mask_r     <= '1;
            tc_flags_r <= '0;
            pri_ptr_r  <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                // The channel in service cannot be reprogrammed under its own feet
                if (cfg_we && (IDX_W'(cfg_ch) == IDX_W'(ch)) &&
                    !((state_r != ST_SI) && (win_r == IDX_W'(ch)))) begin
                    base_addr_r[ch] <= cfg_addr;
                    cur_addr_r[ch]  <= cfg_addr;
                    base_cnt_r[ch]  <= cfg_count;
                    cur_cnt_r[ch]   <= cfg_count;
                    dir_r[ch]       <= cfg_ctrl[CTRL_DIR];
                    autoinit_r[ch]  <= cfg_ctrl[CTRL_AUTOINIT];
                    dec_r[ch]       <= cfg_ctrl[CTRL_ADDR_DEC];
                    mask_r[ch]      <= cfg_ctrl[CTRL_MASK];
                end else if (commit_s && (win_r == IDX_W'(ch))) begin
                    if (tc_hit_s && autoinit_r[ch]) begin
                        cur_addr_r[ch] <= base_addr_r[ch];
                        cur_cnt_r[ch]  <= base_cnt_r[ch];
                    end else begin
                        cur_addr_r[ch] <= step_addr_s;
                        cur_cnt_r[ch]  <= cur_cnt_r[ch] - CNT_W'(1);
                    end
                    if (tc_hit_s && !autoinit_r[ch]) begin
                        mask_r[ch] <= 1'b1;
                    end else begin
                        mask_r[ch] <= mask_r[ch];
                    end
                end else begin
                    cur_addr_r[ch] <= cur_addr_r[ch];
                end
                // A TC set in the same cycle as a status read survives the clear
                if (commit_s && tc_hit_s && (win_r == IDX_W'(ch))) begin
                    tc_flags_r[ch] <= 1'b1;
                end else if (status_rd) begin
                    tc_flags_r[ch] <= 1'b0;
                end else begin
                    tc_flags_r[ch] <= tc_flags_r[ch];
                end
            end
            if (state_r == ST_S4) begin
                pri_ptr_r <= win_r + IDX_W'(1);
            end else begin
                pri_ptr_r <= pri_ptr_r;
            end
        end
    end

endmodule

// File: tb/tb_dma_transfer_sequencer.sv
// Directed bench for dma_transfer_sequencer: an arbitration vector table plus
// hand-written sequences for handshake, TC/autoinit, abort and reset corners.
module tb_dma_transfer_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  dreq;
    logic        hlda;
    logic        rotate_pri;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_addr;
    logic [15:0] cfg_count;
    logic [3:0]  cfg_ctrl;
    logic        status_rd;
    logic        hrq;
    logic [3:0]  dack;
    logic        aen;
    logic        adstb;
    logic        memr;
    logic        memw;
    logic        tc;
    logic [15:0] addr_out;
    logic [3:0]  tc_flags;
    logic [3:0]  mask_out;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    dma_transfer_sequencer dut (
        .clk(clk), .rst(rst), .dreq(dreq), .hlda(hlda), .rotate_pri(rotate_pri),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_count(cfg_count),
        .cfg_ctrl(cfg_ctrl), .status_rd(status_rd), .hrq(hrq), .dack(dack), .aen(aen),
        .adstb(adstb), .memr(memr), .memw(memw), .tc(tc), .addr_out(addr_out),
        .tc_flags(tc_flags), .mask_out(mask_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  dreq;
        logic        rot;
        logic [3:0]  exp_dack;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic program_ch(input logic [1:0] ch, input logic [15:0] a,
                              input logic [15:0] c, input logic [3:0] ctrl);
        cfg_we = 1'b1; cfg_ch = ch; cfg_addr = a; cfg_count = c; cfg_ctrl = ctrl;
        tick();
        cfg_we = 1'b0;
    endtask

    // Run one grant with hlda already high; capture S1 and S4 observations
    task automatic run_grant(output logic [3:0] dk, output logic [15:0] a1,
                             output logic [15:0] a4, output logic t4);
        int n;
        n = 0;
        tick();
        while (!adstb && n < 20) begin
            tick();
            n++;
        end
        check("grant_started", {31'd0, adstb}, 32'd1);
        dk = dack;
        a1 = addr_out;
        tick();
        tick();
        tick();
        t4 = tc;
        a4 = addr_out;
        tick();
    endtask

    logic [3:0]  g_dk;
    logic [15:0] g_a1;
    logic [15:0] g_a4;
    logic        g_tc;

    initial begin
        rst = 1'b0; dreq = 4'b0000; hlda = 1'b0; rotate_pri = 1'b0;
        cfg_we = 1'b0; cfg_ch = 2'd0; cfg_addr = 16'h0000; cfg_count = 16'h0000;
        cfg_ctrl = 4'b0000; status_rd = 1'b0;
        @(negedge clk);

        // Reset state
        do_reset();
        check("rst_hrq", {31'd0, hrq}, 32'd0);
        check("rst_dack", {28'd0, dack}, 32'd0);
        check("rst_strobes", {28'd0, aen, adstb, memr, memw}, 32'd0);
        check("rst_mask", {28'd0, mask_out}, 32'hF);
        check("rst_tcflags", {28'd0, tc_flags}, 32'd0);

        // Single transfer on ch2, read, count 0, hlda two cycles after hrq
        program_ch(2'd2, 16'h1000, 16'h0000, 4'b0000);
        check("t1_mask_prog", {28'd0, mask_out}, 32'hB);
        dreq = 4'b0100;
        tick();
        check("t1_hrq", {31'd0, hrq}, 32'd1);
        tick();
        check("t1_wait_no_strobe", {30'd0, aen, adstb}, 32'd0);
        tick();
        hlda = 1'b1;
        tick();
        check("t1_s1_adstb_aen", {30'd0, aen, adstb}, 32'd3);
        check("t1_s1_dack", {28'd0, dack}, 32'h4);
        check("t1_s1_addr", {16'd0, addr_out}, 32'h1000);
        check("t1_s1_memr", {31'd0, memr}, 32'd0);
        tick();
        check("t1_s2", {28'd0, aen, adstb, memr, memw}, 32'hA);
        tick();
        check("t1_s3", {28'd0, aen, adstb, memr, memw}, 32'hA);
        tick();
        check("t1_s4_strobes", {29'd0, memr, memw, tc}, 32'd1);
        check("t1_s4_addr", {16'd0, addr_out}, 32'h1001);
        check("t1_tcflags", {28'd0, tc_flags}, 32'h4);
        check("t1_mask_set", {28'd0, mask_out}, 32'hF);
        tick();
        check("t1_idle", {26'd0, hrq, aen, dack}, 32'd0);
        dreq = 4'b0000; hlda = 1'b0;
        status_rd = 1'b1;
        tick();
        status_rd = 1'b0;
        check("t1_status_clear", {28'd0, tc_flags}, 32'd0);

        // Fixed then rotating priority, applied back to back from a table
        vecs[0] = '{dreq: 4'b1010, rot: 1'b0, exp_dack: 4'b0010, exp_addr: 16'h0100};
        vecs[1] = '{dreq: 4'b1010, rot: 1'b0, exp_dack: 4'b0010, exp_addr: 16'h0101};
        vecs[2] = '{dreq: 4'b1000, rot: 1'b0, exp_dack: 4'b1000, exp_addr: 16'h0300};
        vecs[3] = '{dreq: 4'b1111, rot: 1'b1, exp_dack: 4'b0001, exp_addr: 16'h0000};
        vecs[4] = '{dreq: 4'b1111, rot: 1'b1, exp_dack: 4'b0010, exp_addr: 16'h0102};
        vecs[5] = '{dreq: 4'b1111, rot: 1'b1, exp_dack: 4'b0100, exp_addr: 16'h0200};
        vecs[6] = '{dreq: 4'b1111, rot: 1'b1, exp_dack: 4'b1000, exp_addr: 16'h0301};
        vecs[7] = '{dreq: 4'b1111, rot: 1'b1, exp_dack: 4'b0001, exp_addr: 16'h0001};
        vecs[8] = '{dreq: 4'b1111, rot: 1'b0, exp_dack: 4'b0001, exp_addr: 16'h0002};
        vecs[9] = '{dreq: 4'b0110, rot: 1'b0, exp_dack: 4'b0010, exp_addr: 16'h0103};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            program_ch(2'(c), 16'(c * 256), 16'h00FF, 4'b0000);
        end
        hlda = 1'b1;
        for (int i = 0; i < 10; i++) begin
            dreq = vecs[i].dreq;
            rotate_pri = vecs[i].rot;
            run_grant(g_dk, g_a1, g_a4, g_tc);
            check($sformatf("arb%0d_dack", i), {28'd0, g_dk}, {28'd0, vecs[i].exp_dack});
            check($sformatf("arb%0d_addr", i), {16'd0, g_a1}, {16'd0, vecs[i].exp_addr});
        end
        dreq = 4'b0000; rotate_pri = 1'b0;

        // Autoinit with decrementing address across the wrap
        do_reset();
        program_ch(2'd0, 16'h0000, 16'h0001, 4'b0110);
        hlda = 1'b1;
        dreq = 4'b0001;
        run_grant(g_dk, g_a1, g_a4, g_tc);
        check("t4_x1_addr4", {16'd0, g_a4}, 32'hFFFF);
        check("t4_x1_tc", {31'd0, g_tc}, 32'd0);
        run_grant(g_dk, g_a1, g_a4, g_tc);
        check("t4_x2_addr1", {16'd0, g_a1}, 32'hFFFF);
        check("t4_x2_addr4", {16'd0, g_a4}, 32'hFFFE);
        check("t4_x2_tc", {31'd0, g_tc}, 32'd1);
        check("t4_tcflags", {28'd0, tc_flags}, 32'h1);
        run_grant(g_dk, g_a1, g_a4, g_tc);
        check("t4_reload_addr", {16'd0, g_a1}, 32'h0000);
        check("t4_reload_tc", {31'd0, g_tc}, 32'd0);
        check("t4_mask", {28'd0, mask_out}, 32'hE);
        dreq = 4'b0000;

        // hlda lost in S2 aborts the cycle without touching the channel
        do_reset();
        program_ch(2'd1, 16'h2000, 16'h0003, 4'b0000);
        hlda = 1'b1;
        dreq = 4'b0010;
        tick();
        tick();
        tick();
        check("t5_s2_memr", {31'd0, memr}, 32'd1);
        hlda = 1'b0;
        tick();
        check("t5_abort", {25'd0, hrq, aen, memr, dack}, 32'd0);
        hlda = 1'b1;
        run_grant(g_dk, g_a1, g_a4, g_tc);
        check("t5_reserve_dack", {28'd0, g_dk}, 32'h2);
        check("t5_addr_kept", {16'd0, g_a1}, 32'h2000);
        check("t5_no_tc", {31'd0, g_tc}, 32'd0);
        dreq = 4'b0000;

        // Config to the active channel is dropped; reset mid-transfer clears all
        do_reset();
        program_ch(2'd2, 16'h3000, 16'h0000, 4'b0000);
        hlda = 1'b1;
        dreq = 4'b0100;
        tick();
        tick();
        check("t6_s1", {31'd0, adstb}, 32'd1);
        program_ch(2'd0, 16'h0000, 16'h0000, 4'b0000);
        check("t6_other_ch_write", {28'd0, mask_out}, 32'hA);
        program_ch(2'd2, 16'h5555, 16'h0005, 4'b1000);
        check("t6_active_write_dropped", {28'd0, mask_out}, 32'hA);
        check("t6_s3_memr", {31'd0, memr}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dreq = 4'b0000;
        check("t6_rst_outs", {20'd0, hrq, aen, adstb, memr, memw, tc, 2'd0, dack}, 32'd0);
        check("t6_rst_addr", {16'd0, addr_out}, 32'd0);
        check("t6_rst_mask", {28'd0, mask_out}, 32'hF);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
